// File: rtl/led_frame_buffer.sv
// Double-buffered 16x16 red/green pixel store with frame-synchronous swap and
// LED driver row-scan strobe. Pixel (row, col) lives at bit row*16 + col of each plane.
module led_frame_buffer #(
    parameter int unsigned SCAN_DIV      = 16,
    parameter int unsigned FRAME_PULSES  = 16,
    parameter int unsigned CLEAR_ON_SWAP = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_valid_i,
    output logic         wr_ready_o,
    input  logic [3:0]   wr_row_i,
    input  logic [3:0]   wr_col_i,
    input  logic         wr_red_i,
    input  logic         wr_grn_i,
    input  logic         clr_req_i,
    input  logic         swap_req_i,
    output logic         busy_o,
    output logic         swap_done_o,
    output logic [255:0] red_pixels_o,
    output logic [255:0] grn_pixels_o,
    output logic         enable_count_o
);

    localparam int unsigned DivW   = $clog2(SCAN_DIV);
    localparam int unsigned FrameW = (FRAME_PULSES > 1) ? $clog2(FRAME_PULSES) : 1;
    localparam logic [DivW-1:0]   DivMax   = DivW'(SCAN_DIV - 1);
    localparam logic [DivW-1:0]   DivPre   = DivW'(SCAN_DIV - 2);
    localparam logic [FrameW-1:0] FrameMax = FrameW'(FRAME_PULSES - 1);

    typedef enum logic [1:0] {StIdle, StClear, StSwap} state_e;

    state_e              state_q;
    logic [DivW-1:0]     div_cnt_q;
    logic [FrameW-1:0]   frame_cnt_q;
    logic                enable_count_q;
    logic                front_sel_q;
    logic                swap_done_q;
    logic [3:0]          clr_row_q;
    logic [255:0]        red0_q, grn0_q, red1_q, grn1_q;
    logic                frame_wrap;
    logic [7:0]          wr_idx;
    logic [7:0]          clr_base;

    assign frame_wrap = enable_count_q && (frame_cnt_q == FrameMax);
    assign wr_idx     = {wr_row_i, wr_col_i};
    assign clr_base   = {clr_row_q, 4'h0};

    // Free-running scan divider; strobe is registered one count early so it
    // lands on the cycle where div_cnt_q == SCAN_DIV-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q      <= '0;
            enable_count_q <= 1'b0;
            frame_cnt_q    <= '0;
        end else begin
            div_cnt_q      <= (div_cnt_q == DivMax) ? '0 : div_cnt_q + 1'b1;
            enable_count_q <= (div_cnt_q == DivPre);
            if (enable_count_q) begin
                frame_cnt_q <= (frame_cnt_q == FrameMax) ? '0 : frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            front_sel_q <= 1'b0;
            swap_done_q <= 1'b0;
            clr_row_q   <= 4'h0;
            red0_q      <= '0;
            grn0_q      <= '0;
            red1_q      <= '0;
            grn1_q      <= '0;
        end else begin
            swap_done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    // The back buffer is buffer 1 when front_sel_q is 0.
                    if (wr_valid_i) begin
                        if (front_sel_q) begin
                            red0_q[wr_idx] <= wr_red_i;
                            grn0_q[wr_idx] <= wr_grn_i;
                        end else begin
                            red1_q[wr_idx] <= wr_red_i;
                            grn1_q[wr_idx] <= wr_grn_i;
                        end
                    end
                    if (swap_req_i) begin
                        state_q <= StSwap;
                    end else if (clr_req_i) begin
                        state_q   <= StClear;
                        clr_row_q <= 4'h0;
                    end
                end
                StSwap: begin
                    if (frame_wrap) begin
                        front_sel_q <= ~front_sel_q;
                        swap_done_q <= 1'b1;
                        clr_row_q   <= 4'h0;
                        state_q     <= (CLEAR_ON_SWAP != 0) ? StClear : StIdle;
                    end
                end
                StClear: begin
                    if (front_sel_q) begin
                        red0_q[clr_base +: 16] <= 16'h0000;
                        grn0_q[clr_base +: 16] <= 16'h0000;
                    end else begin
                        red1_q[clr_base +: 16] <= 16'h0000;
                        grn1_q[clr_base +: 16] <= 16'h0000;
                    end
                    clr_row_q <= clr_row_q + 4'h1;
                    if (clr_row_q == 4'hF) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign wr_ready_o     = (state_q == StIdle);
    assign busy_o         = ~wr_ready_o;
    assign swap_done_o    = swap_done_q;
    assign enable_count_o = enable_count_q;
    assign red_pixels_o   = front_sel_q ? red1_q : red0_q;
    assign grn_pixels_o   = front_sel_q ? grn1_q : grn0_q;

endmodule

// File: tb/tb_led_frame_buffer.sv
// Scoreboard bench for led_frame_buffer: expected frames are queued at swap
// request and compared when swap_done fires.
module tb_led_frame_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_valid, wr_ready, wr_red, wr_grn;
    logic [3:0]   wr_row, wr_col;
    logic         clr_req, swap_req, busy, swap_done, enable_count;
    logic [255:0] red_pixels, grn_pixels;

    int checks   = 0;
    int failures = 0;
    int unsigned cyc = 0;

    logic [15:0]  mback_r [16];
    logic [15:0]  mback_g [16];
    logic [15:0]  mfront_r[16];
    logic [15:0]  mfront_g[16];
    logic [255:0] exp_r_q[$];
    logic [255:0] exp_g_q[$];

    always #5 clk = ~clk;

    // Cycle index since the last reset edge; matches the scan phase.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    led_frame_buffer #(
        .SCAN_DIV     (4),
        .FRAME_PULSES (4),
        .CLEAR_ON_SWAP(1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_valid_i    (wr_valid),
        .wr_ready_o    (wr_ready),
        .wr_row_i      (wr_row),
        .wr_col_i      (wr_col),
        .wr_red_i      (wr_red),
        .wr_grn_i      (wr_grn),
        .clr_req_i     (clr_req),
        .swap_req_i    (swap_req),
        .busy_o        (busy),
        .swap_done_o   (swap_done),
        .red_pixels_o  (red_pixels),
        .grn_pixels_o  (grn_pixels),
        .enable_count_o(enable_count)
    );

    function automatic logic [255:0] pack(input logic [15:0] p[16]);
        logic [255:0] v;
        for (int r = 0; r < 16; r++) v[r*16 +: 16] = p[r];
        return v;
    endfunction

    task automatic model_reset;
        for (int i = 0; i < 16; i++) begin
            mback_r[i] = '0; mback_g[i] = '0; mfront_r[i] = '0; mfront_g[i] = '0;
        end
        exp_r_q.delete();
        exp_g_q.delete();
    endtask

    task automatic do_reset;
        rst = 1'b1; wr_valid = 1'b0; clr_req = 1'b0; swap_req = 1'b0;
        wr_row = 4'h0; wr_col = 4'h0; wr_red = 1'b0; wr_grn = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic write_px(input int r, input int c, input logic rv, input logic gv);
        wr_valid = 1'b1; wr_row = 4'(r); wr_col = 4'(c); wr_red = rv; wr_grn = gv;
        mback_r[r][c] = rv;
        mback_g[r][c] = gv;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic check_clear_len(input string name);
        int n = 0;
        while (!wr_ready && n < 40) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL %s clear_len got=%0d exp=16", name, n);
        end
    endtask

    task automatic align(input int unsigned k);
        for (int i = 0; i < 16 && (cyc % 16) != k; i++) @(negedge clk);
    endtask

    task automatic do_swap(input string name, input bit wr_en, input int wr_r, input int wr_c,
                           input logic rv, input logic gv, input bit clr_en, input bit clr_during);
        logic [255:0] old_r, old_g, er, eg;
        int unsigned  exp_done;
        bit           found, leak;
        if (wr_en) begin
            wr_valid = 1'b1; wr_row = 4'(wr_r); wr_col = 4'(wr_c); wr_red = rv; wr_grn = gv;
            mback_r[wr_r][wr_c] = rv;
            mback_g[wr_r][wr_c] = gv;
        end
        clr_req  = clr_en;
        swap_req = 1'b1;
        old_r = pack(mfront_r);
        old_g = pack(mfront_g);
        exp_r_q.push_back(pack(mback_r));
        exp_g_q.push_back(pack(mback_g));
        @(negedge clk);
        wr_valid = 1'b0; swap_req = 1'b0; clr_req = clr_during;
        exp_done = (cyc / 16 + 1) * 16;
        for (int i = 0; i < 16; i++) begin
            mfront_r[i] = mback_r[i]; mfront_g[i] = mback_g[i];
            mback_r[i] = '0; mback_g[i] = '0;
        end
        found = 1'b0;
        leak  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (swap_done) begin
                found = 1'b1;
                break;
            end
            if (red_pixels !== old_r || grn_pixels !== old_g || busy !== 1'b1) leak = 1'b1;
            @(negedge clk);
            clr_req = 1'b0;
        end
        clr_req = 1'b0;
        er = exp_r_q.pop_front();
        eg = exp_g_q.pop_front();
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL %s swap_done timeout got=0 exp=1", name);
        end else begin
            checks++;
            if (cyc != exp_done) begin
                failures++;
                $display("FAIL %s swap_done_cycle got=%0d exp=%0d", name, cyc, exp_done);
            end
            checks++;
            if (leak) begin
                failures++;
                $display("FAIL %s pre_swap_front got=changed exp=stable_busy", name);
            end
            checks++;
            if (red_pixels !== er) begin
                failures++;
                $display("FAIL %s red_frame got=%h exp=%h", name, red_pixels, er);
            end
            checks++;
            if (grn_pixels !== eg) begin
                failures++;
                $display("FAIL %s grn_frame got=%h exp=%h", name, grn_pixels, eg);
            end
            check_clear_len(name);
        end
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if (red_pixels !== '0 || grn_pixels !== '0) begin
            failures++;
            $display("FAIL reset_pixels got=%h/%h exp=0", red_pixels, grn_pixels);
        end
        checks++;
        if (wr_ready !== 1'b1 || busy !== 1'b0 || swap_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=rdy%b busy%b done%b exp=rdy1 busy0 done0",
                     wr_ready, busy, swap_done);
        end
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (enable_count !== ((cyc % 4) == 3)) begin
                failures++;
                $display("FAIL reset_enable_count cyc=%0d got=%b exp=%b",
                         cyc, enable_count, (cyc % 4) == 3);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_write_swap;
        write_px(2, 3, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        checks++;
        if (red_pixels !== '0 || grn_pixels !== '0) begin
            failures++;
            $display("FAIL t2_no_early_show got=%h/%h exp=0", red_pixels, grn_pixels);
        end
        do_swap("t2_swap", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (red_pixels[2*16+3] !== 1'b1 || grn_pixels[2*16+3] !== 1'b1) begin
            failures++;
            $display("FAIL t2_pixel_2_3 got=%b%b exp=11", red_pixels[35], grn_pixels[35]);
        end
    endtask

    task automatic test_clear_on_swap;
        do_swap("t3_swap_back", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_clear;
        bit stall = 1'b0;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                if (wr_ready !== 1'b1) stall = 1'b1;
                write_px(r, c, 1'b1, 1'b1);
            end
        end
        checks++;
        if (stall) begin
            failures++;
            $display("FAIL t4_fill_ready got=0 exp=1");
        end
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mback_r[i] = '0; mback_g[i] = '0;
        end
        check_clear_len("t4_clear");
        write_px(7, 9, 1'b0, 1'b1);
        do_swap("t4_verify", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        write_px(4, 5, 1'b1, 1'b0);
        do_swap("t5_combined", 1'b1, 5, 7, 1'b0, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_rst_mid_swap;
        bit seen = 1'b0;
        write_px(3, 3, 1'b1, 1'b1);
        align(2);
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();
        checks++;
        if (wr_ready !== 1'b1 || red_pixels !== '0 || grn_pixels !== '0) begin
            failures++;
            $display("FAIL t6_swap_rst got=rdy%b px=%h exp=rdy1 px=0", wr_ready, red_pixels);
        end
        for (int i = 0; i < 20; i++) begin
            if (swap_done) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL t6_no_swap_done got=1 exp=0");
        end
        do_swap("t6_swap_verify", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_rst_mid_clear;
        write_px(6, 6, 1'b1, 1'b1);
        do_swap("t6_pre", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        write_px(8, 8, 1'b1, 1'b0);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (3) @(negedge clk);
        do_reset();
        checks++;
        if (wr_ready !== 1'b1 || red_pixels !== '0 || grn_pixels !== '0) begin
            failures++;
            $display("FAIL t6_clear_rst got=rdy%b px=%h exp=rdy1 px=0", wr_ready, grn_pixels);
        end
        do_swap("t6_clear_verify", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; wr_valid = 1'b0; clr_req = 1'b0; swap_req = 1'b0;
        wr_row = 4'h0; wr_col = 4'h0; wr_red = 1'b0; wr_grn = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_write_swap();
        test_clear_on_swap();
        test_clear();
        test_back_to_back();
        test_rst_mid_swap();
        test_rst_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
